// File: rtl/sccb_init_sequencer.sv
// Table-driven SCCB register initialiser: walks a config ROM and issues writes,
// optional read-back verification with retry, ms delays and handshake timeouts.
module sccb_init_sequencer #(
  parameter logic [7:0]  DEV_ID      = 8'h42,
  parameter int unsigned XCLK_FREQ   = 8_000_000,
  parameter int unsigned TBL_AW      = 8,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned TIMEOUT_CYC = 200_000
) (
  input  logic              XCLK,
  input  logic              RST,
  input  logic              go,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [17:0]       tbl_data,
  output logic              start,
  output logic              RW,
  output logic [7:0]        ip_addr,
  output logic [7:0]        sub_addr,
  output logic [7:0]        data_in,
  input  logic [7:0]        data_out,
  input  logic              done,
  output logic              busy,
  output logic              init_done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [TBL_AW-1:0] err_addr
);

  localparam int unsigned MS_CYC = (XCLK_FREQ >= 1000) ? XCLK_FREQ / 1000 : 1;
  localparam int unsigned MS_W   = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
  localparam int unsigned TMO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned RTY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [1:0] ERR_VERIFY  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, WR_REQ, WR_ACK, RD_REQ, RD_ACK,
    CHECK, DELAY, NEXT, FIN, FAIL
  } state_e;

  typedef enum logic [1:0] {
    OP_WRV = 2'b00,
    OP_WR  = 2'b01,
    OP_DLY = 2'b10,
    OP_END = 2'b11
  } op_e;

  state_e            state_q, state_d;
  logic [TBL_AW-1:0] tbl_addr_q, tbl_addr_d;
  logic [7:0]        sub_q, sub_d;
  logic [7:0]        dat_q, dat_d;
  logic              vfy_q, vfy_d;
  logic              rw_q, rw_d;
  logic [7:0]        rd_q, rd_d;
  logic [RTY_W-1:0]  retry_q, retry_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [MS_W-1:0]   cyc_q, cyc_d;
  logic [7:0]        ms_q, ms_d;
  logic              busy_q, busy_d;
  logic              init_done_q, init_done_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [TBL_AW-1:0] err_addr_q, err_addr_d;

  logic tmo_hit;
  op_e  op;

  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
  assign op      = op_e'(tbl_data[17:16]);

  always_ff @(posedge XCLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      tbl_addr_q  <= '0;
      sub_q       <= '0;
      dat_q       <= '0;
      vfy_q       <= 1'b0;
      rw_q        <= 1'b0;
      rd_q        <= '0;
      retry_q     <= '0;
      tmo_q       <= '0;
      cyc_q       <= '0;
      ms_q        <= '0;
      busy_q      <= 1'b0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      tbl_addr_q  <= tbl_addr_d;
      sub_q       <= sub_d;
      dat_q       <= dat_d;
      vfy_q       <= vfy_d;
      rw_q        <= rw_d;
      rd_q        <= rd_d;
      retry_q     <= retry_d;
      tmo_q       <= tmo_d;
      cyc_q       <= cyc_d;
      ms_q        <= ms_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      err_addr_q  <= err_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tbl_addr_d  = tbl_addr_q;
    sub_d       = sub_q;
    dat_d       = dat_q;
    vfy_d       = vfy_q;
    rw_d        = rw_q;
    rd_d        = rd_q;
    retry_d     = retry_q;
    tmo_d       = tmo_q;
    cyc_d       = cyc_q;
    ms_d        = ms_q;
    busy_d      = busy_q;
    init_done_d = init_done_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    err_addr_d  = err_addr_q;

    case (state_q)
      IDLE, FIN, FAIL: begin
        if (go) begin
          init_done_d = 1'b0;
          err_d       = 1'b0;
          err_code_d  = '0;
          err_addr_d  = '0;
          tbl_addr_d  = '0;
          retry_d     = '0;
          busy_d      = 1'b1;
          state_d     = FETCH;
        end
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        sub_d = tbl_data[15:8];
        dat_d = tbl_data[7:0];
        vfy_d = (op == OP_WRV);
        case (op)
          OP_WRV, OP_WR: state_d = WR_REQ;
          OP_DLY: begin
            ms_d    = tbl_data[7:0];
            cyc_d   = '0;
            state_d = (tbl_data[7:0] == 8'd0) ? NEXT : DELAY;
          end
          default: state_d = FIN;
        endcase
      end
      // In every handshake state a completing done takes priority over timeout.
      WR_REQ: begin
        if (done) state_d = WR_ACK;
        else if (tmo_hit) begin
          state_d    = FAIL;
          err_code_d = ERR_TIMEOUT;
        end else tmo_d = tmo_q + 1'b1;
      end
      WR_ACK: begin
        if (!done) state_d = vfy_q ? RD_REQ : NEXT;
        else if (tmo_hit) begin
          state_d    = FAIL;
          err_code_d = ERR_TIMEOUT;
        end else tmo_d = tmo_q + 1'b1;
      end
      RD_REQ: begin
        if (done) begin
          rd_d    = data_out;
          state_d = RD_ACK;
        end else if (tmo_hit) begin
          state_d    = FAIL;
          err_code_d = ERR_TIMEOUT;
        end else tmo_d = tmo_q + 1'b1;
      end
      RD_ACK: begin
        if (!done) state_d = CHECK;
        else if (tmo_hit) begin
          state_d    = FAIL;
          err_code_d = ERR_TIMEOUT;
        end else tmo_d = tmo_q + 1'b1;
      end
      CHECK: begin
        if (rd_q == dat_q) state_d = NEXT;
        else if (retry_q < RTY_W'(MAX_RETRY)) begin
          retry_d = retry_q + 1'b1;
          state_d = WR_REQ;
        end else begin
          state_d    = FAIL;
          err_code_d = ERR_VERIFY;
        end
      end
      DELAY: begin
        if (cyc_q == MS_W'(MS_CYC - 1)) begin
          cyc_d = '0;
          if (ms_q == 8'd1) state_d = NEXT;
          else ms_d = ms_q - 8'd1;
        end else cyc_d = cyc_q + 1'b1;
      end
      NEXT: begin
        retry_d = '0;
        if (&tbl_addr_q) state_d = FIN;
        else begin
          tbl_addr_d = tbl_addr_q + 1'b1;
          state_d    = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    // Entry actions: RW is fixed for the whole request/ack pair it belongs to.
    if (state_d != state_q) begin
      tmo_d = '0;
      if (state_d == WR_REQ) rw_d = 1'b0;
      if (state_d == RD_REQ) rw_d = 1'b1;
      if (state_d == FIN) begin
        busy_d      = 1'b0;
        init_done_d = 1'b1;
      end
      if (state_d == FAIL) begin
        busy_d     = 1'b0;
        err_d      = 1'b1;
        err_addr_d = tbl_addr_q;
      end
    end
  end

  assign start     = (state_q == WR_REQ) || (state_q == RD_REQ);
  assign RW        = rw_q;
  assign ip_addr   = DEV_ID;
  assign sub_addr  = sub_q;
  assign data_in   = dat_q;
  assign tbl_addr  = tbl_addr_q;
  assign busy      = busy_q;
  assign init_done = init_done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Bench for sccb_init_sequencer: SCCB core model plus table-walking reference model.
module tb_sccb_init_sequencer;

  localparam int unsigned AW    = 4;
  localparam int unsigned XF    = 8000;
  localparam int unsigned MS    = XF / 1000;
  localparam int unsigned MR    = 3;
  localparam int unsigned TMO   = 100;
  localparam int unsigned LIMIT = 20000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          go  = 1'b0;
  logic [AW-1:0] tbl_addr;
  logic [17:0]   tbl_data;
  logic          start, RW;
  logic [7:0]    ip_addr, sub_addr, data_in;
  logic [7:0]    data_out;
  logic          done;
  logic          busy, init_done, err;
  logic [1:0]    err_code;
  logic [AW-1:0] err_addr;

  sccb_init_sequencer #(
    .DEV_ID(8'h42), .XCLK_FREQ(XF), .TBL_AW(AW), .MAX_RETRY(MR), .TIMEOUT_CYC(TMO)
  ) dut (
    .XCLK(clk), .RST(rst), .go(go), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .start(start), .RW(RW), .ip_addr(ip_addr), .sub_addr(sub_addr), .data_in(data_in),
    .data_out(data_out), .done(done), .busy(busy), .init_done(init_done), .err(err),
    .err_code(err_code), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [17:0] rom [16];
  always @(posedge clk) tbl_data <= rom[tbl_addr];

  typedef struct packed { logic rw; logic [7:0] sub; logic [7:0] dat; } txn_t;
  txn_t obs_q[$];
  txn_t exp_q[$];

  logic [7:0]  regs [256];
  int unsigned bad_left [256];
  bit          silent  = 1'b0;
  int unsigned lat_max = 2;

  // Core model: random ack latency, done lingers 0..1 cycles after start drops.
  int unsigned cm_ph   = 0;
  int unsigned cm_wait = 0;
  txn_t        cm_cur;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cm_ph = 0;
      done     <= 1'b0;
      data_out <= '0;
    end else begin
      case (cm_ph)
        0: if (start) begin
          cm_cur  = {RW, sub_addr, data_in};
          cm_wait = $urandom_range(lat_max, 0);
          cm_ph   = 1;
        end
        1: begin
          if (!start) cm_ph = 0;
          else if (!silent) begin
            if (cm_wait == 0) begin
              check("hold_stable", {RW, sub_addr, data_in}, cm_cur);
              obs_q.push_back(cm_cur);
              if (!RW) regs[sub_addr] = data_in;
              else if (bad_left[sub_addr] == 255) data_out <= regs[sub_addr] ^ 8'hFF;
              else if (bad_left[sub_addr] > 0) begin
                data_out <= regs[sub_addr] ^ 8'hFF;
                bad_left[sub_addr] = bad_left[sub_addr] - 1;
              end else data_out <= regs[sub_addr];
              done <= 1'b1;
              cm_ph = 2;
            end else cm_wait = cm_wait - 1;
          end
        end
        2: if (!start) begin
          cm_wait = $urandom_range(1, 0);
          cm_ph   = 3;
        end
        default: begin
          if (cm_wait == 0) begin
            done <= 1'b0;
            cm_ph = 0;
          end else cm_wait = cm_wait - 1;
        end
      endcase
    end
  end

  logic start_prev = 1'b0;
  always @(posedge clk) begin
    if (start && !start_prev) check("stale_done", done, 1'b0);
    start_prev <= start;
  end

  bit          exp_done, exp_err, exp_haswr;
  logic [1:0]  exp_code;
  int unsigned exp_eaddr, exp_taddr, exp_cyc;

  // Reference: walk the table entry by entry, accounting transactions and idle cycles.
  task automatic ref_model();
    int unsigned bad [256];
    int unsigned a;
    logic [1:0]  op;
    logic [7:0]  s, d;
    bit          ok;
    foreach (bad[i]) bad[i] = bad_left[i];
    exp_q.delete();
    exp_done = 0; exp_err = 0; exp_code = 0; exp_eaddr = 0; exp_cyc = 0; exp_haswr = 0;
    a = 0;
    forever begin
      {op, s, d} = rom[a];
      if (op == 2'b11) begin
        exp_cyc += 2;
        exp_done = 1;
        break;
      end
      exp_cyc += 3;
      if (op == 2'b10) exp_cyc += d * MS;
      else begin
        exp_haswr = 1;
        if (silent) begin
          exp_err = 1; exp_code = 2'b10; exp_eaddr = a;
          break;
        end
        exp_q.push_back({1'b0, s, d});
        if (op == 2'b00) begin
          ok = 0;
          for (int t = 0; t <= int'(MR); t++) begin
            if (t > 0) exp_q.push_back({1'b0, s, d});
            exp_q.push_back({1'b1, s, d});
            if (bad[s] == 255) continue;
            if (bad[s] > 0) begin
              bad[s]--;
              continue;
            end
            ok = 1;
            break;
          end
          if (!ok) begin
            exp_err = 1; exp_code = 2'b01; exp_eaddr = a;
            break;
          end
        end
      end
      if (a == 15) begin
        exp_done = 1;
        break;
      end
      a++;
    end
    exp_taddr = a;
  endtask

  task automatic run_table(input string name);
    int unsigned cyc, first_start, start_cyc, go_at;
    ref_model();
    obs_q.delete();
    go_at = $urandom_range(40, 3);
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    cyc = 0; first_start = 0; start_cyc = 0;
    while (busy && cyc < LIMIT) begin
      if (cyc == go_at) go = 1'b1;
      @(posedge clk); #1 go = 1'b0;
      cyc++;
      if (start) begin
        start_cyc++;
        if (first_start == 0) first_start = cyc + 1;
      end
    end
    check({name, ":busy_drop"}, busy, 1'b0);
    if (busy) begin
      rst = 1'b1; #1 rst = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check({name, ":init_done"}, init_done, exp_done);
    check({name, ":err"}, err, exp_err);
    check({name, ":err_code"}, err_code, exp_code);
    check({name, ":err_addr"}, err_addr, exp_eaddr);
    check({name, ":tbl_addr"}, tbl_addr, exp_taddr);
    check({name, ":start_low"}, start, 1'b0);
    check({name, ":ntxn"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({name, ":txn"}, obs_q[i], exp_q[i]);
    if (rom[0][17] == 1'b0) check({name, ":go_to_start"}, first_start, 3);
    if (silent && exp_haswr) check({name, ":tmo_cycles"}, start_cyc, TMO);
    if (!exp_haswr) check({name, ":duration"}, cyc, exp_cyc);
  endtask

  task automatic set_rom(input logic [17:0] e0, input logic [17:0] e1, input logic [17:0] e2);
    for (int i = 0; i < 16; i++) rom[i] = 18'h3_0000;
    rom[0] = e0; rom[1] = e1; rom[2] = e2;
    for (int s = 0; s < 256; s++) bad_left[s] = 0;
  endtask

  task automatic gen_table(input bit delay_only);
    int unsigned r;
    logic [1:0]  op;
    for (int i = 0; i < 16; i++) begin
      r = $urandom_range(99, 0);
      if (delay_only) op = (r < 12) ? 2'b11 : 2'b10;
      else if (r < 8) op = 2'b11;
      else if (r < 18) op = 2'b10;
      else if (r < 58) op = 2'b00;
      else op = 2'b01;
      if (op == 2'b10) rom[i] = {op, 8'($urandom), 8'($urandom_range(2, 0))};
      else rom[i] = {op, 8'($urandom_range(7, 0)), 8'($urandom)};
    end
    for (int s = 0; s < 256; s++) bad_left[s] = 0;
    for (int k = 0; k < 3; k++) begin
      r = $urandom_range(9, 0);
      bad_left[$urandom_range(7, 0)] = (r == 0) ? 255 : r % 4;
    end
    lat_max = $urandom_range(3, 0);
  endtask

  initial begin
    #(900_000);
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < 256; s++) regs[s] = '0;
    set_rom(18'h1_1280, 18'h0_1101, 18'h3_0000);
    #1 rst = 1'b1;
    #1;
    check("rst_start", start, 1'b0);
    check("rst_rw", RW, 1'b0);
    check("rst_sub", sub_addr, 8'h00);
    check("rst_data_in", data_in, 8'h00);
    check("rst_ip_addr", ip_addr, 8'h42);
    check("rst_tbl_addr", tbl_addr, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_flags", {init_done, err, err_code}, 4'b0000);
    check("rst_err_addr", err_addr, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    set_rom(18'h1_1280, 18'h0_1101, 18'h3_0000);
    run_table("basic");
    set_rom(18'h1_1280, 18'h0_1101, 18'h3_0000);
    bad_left[8'h11] = 255;
    run_table("verify_fail");
    set_rom(18'h1_1280, 18'h0_1101, 18'h3_0000);
    bad_left[8'h11] = 1;
    run_table("retry_once");
    set_rom(18'h1_1280, 18'h0_1101, 18'h3_0000);
    silent = 1'b1;
    run_table("timeout");
    silent = 1'b0;
    set_rom(18'h2_0003, 18'h3_0000, 18'h3_0000);
    run_table("delay3");
    set_rom(18'h2_0000, 18'h3_0000, 18'h3_0000);
    run_table("delay0");
    set_rom(18'h2_0003, 18'h2_0000, 18'h3_0000);
    run_table("delay3_0");

    set_rom(18'h1_1280, 18'h0_1101, 18'h3_0000);
    silent = 1'b1;
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("rst_mid_pre", start, 1'b1);
    @(negedge clk) rst = 1'b1;
    #1;
    check("rst_mid_start", start, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_addr", tbl_addr, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    silent = 1'b0;
    run_table("rst_restart");

    for (int n = 0; n < 40; n++) begin
      gen_table(n % 4 == 3);
      run_table($sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
